ai_accel_wb_loader: RTL
=======================

Name: ai_accel_wb_loader

Overview:
- Wishbone classic master that copies a block of 32-bit words from a source region into the AI accelerator's Wishbone slave window, one word at a time. Typical use: matrix A/B operand regions, or the control registers.
- Sits directly upstream of the accelerator top. It replaces the CPU/bench-driven word-by-word writes with a hardware sequencer started by a single pulse.
- Read from source and write to destination share one master port behind the system interconnect.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width; address stride is DATA_W/8 bytes (4).
- LEN_W, 16, width of word-count input.
- TIMEOUT_CYCLES, 255, cycles a strobe may wait for ack before abort; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- start_i  in  1  single-cycle start request
- src_addr_i  in  ADDR_W  source byte address, word aligned
- dst_addr_i  in  ADDR_W  destination byte address, word aligned
- len_i  in  LEN_W  number of words to copy
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at completion or abort
- err_o  out  1  one-cycle pulse together with done_o on timeout abort
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_addr_o  out  ADDR_W  address
- wbm_data_o  out  DATA_W  write data
- wbm_data_i  in  DATA_W  read data
- wbm_ack_i  in  1  slave acknowledge

Behaviour:
- Reset: one clock with wb_rst_i=1 synchronously forces state IDLE, and all outputs to 0. This applies even mid-transfer: the bus is released on that edge and no done_o or err_o is issued.
- All outputs are registered.
- States: IDLE, RD, GAP_R, WR, GAP_W, FIN, ABORT.
- IDLE:
  - start_i=1 with len_i!=0: latch src, dst and len into internal registers, then go to RD.
  - start_i=1 with len_i=0: go to FIN; no bus activity.
  - start_i outside IDLE is ignored; latched values do not change.
- RD: cyc=stb=1, we=0, addr=cur_src.
  - On a clock edge with ack_i=1: capture data_i into the word buffer, go to GAP_R.
- GAP_R: cyc=stb=0 for exactly one cycle, so registered slaves can drop ack. Then go to WR.
- WR: cyc=stb=we=1, addr=cur_dst, data_o=buffer.
  - On ack_i=1: cur_src+=4, cur_dst+=4, remaining-=1, go to GAP_W.
- GAP_W: one idle bus cycle. If remaining==0, go to FIN; else go to RD.
- FIN: done_o=1 for one cycle, busy_o=0 on the following cycle, return to IDLE.
- ABORT: done_o=1 and err_o=1 for one cycle, bus idle, return to IDLE. The partially copied words are left in place.
- busy_o=1 in every state except IDLE. It is also 1 during FIN and ABORT and drops on the cycle after done_o.
- Timeout:
  - A counter clears on entry to RD or WR and increments each cycle in those states while ack_i=0.
  - When it reaches TIMEOUT_CYCLES, the next state is ABORT and the bus drops.
  - Simultaneous ack_i=1 and timeout expiry: ack wins.
- ack_i outside RD/WR is ignored.
- Address arithmetic wraps modulo 2^ADDR_W. Low 2 address bits are passed through unchanged; misaligned inputs are not checked.
- Latency with a zero-wait slave (ack in the first strobe cycle): 4 cycles per word. Total from the start edge to done_o is 4*len+1 cycles.

Decomposition:
- Shared package ai_accel_pkg holds:
  - the state enum;
  - the stride constant WORD_BYTES=4;
  - accelerator register offsets: CTRL_OP=0x00, W_A=0x04, H_A=0x08, W_B=0x0C, H_B=0x10, GO=0x14, MATRIX_A_OFS=0x18.
- The timeout counter is a natural sub-module: wb_ack_timeout (enable, clear, expired).

Test Plan:
- Copy 4 words from src=0x1000 (memory holds -3,-15,-6,7) to dst=0x3200_0018 using a 1-wait-state slave model.
  - Required: writes land at 0x32000018, 0x3200001C, 0x32000020, 0x32000024 with the same data, in order.
  - Required: done_o pulses once; err_o stays 0.
- len_i=0 with start_i.
  - Required: done_o pulses on the second edge after start; wbm_cyc_o never asserts.
- start_i pulsed again mid-transfer with different src, dst and len.
  - Required: the original transfer completes unchanged; exactly one done_o.
- Slave never acks the 2nd read, TIMEOUT_CYCLES=8.
  - Required: stb is held for 8 cycles, then cyc drops; done_o=err_o=1 for one cycle; exactly 1 write observed.
- wb_rst_i asserted during a WR phase.
  - Required: cyc, stb, we, busy_o are 0 after that edge; no done_o; a new start afterwards works normally.
- Zero-wait slave, len=2.
  - Required: done_o exactly 9 cycles after the start edge; a one-cycle cyc=0 gap between each read and its write.

Source files
------------

// File: rtl/ai_accel_pkg.sv
// Shared definitions for the AI accelerator Wishbone block loader.
// Holds the loader state encoding, the word stride and the accelerator
// slave-window register offsets that loader destinations usually target.
package ai_accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_GAP_R = 3'd2,
        ST_WR    = 3'd3,
        ST_GAP_W = 3'd4,
        ST_FIN   = 3'd5,
        ST_ABORT = 3'd6
    } loader_state_t;

    // Byte stride between consecutive 32-bit words.
    localparam int WORD_BYTES = 4;

    // Accelerator slave-window register offsets.
    localparam logic [31:0] CTRL_OP      = 32'h0000_0000;
    localparam logic [31:0] W_A          = 32'h0000_0004;
    localparam logic [31:0] H_A          = 32'h0000_0008;
    localparam logic [31:0] W_B          = 32'h0000_000C;
    localparam logic [31:0] H_B          = 32'h0000_0010;
    localparam logic [31:0] GO           = 32'h0000_0014;
    localparam logic [31:0] MATRIX_A_OFS = 32'h0000_0018;

endpackage

// File: rtl/wb_ack_timeout.sv
// Acknowledge watchdog for one Wishbone strobe.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_clear       hold the count at zero (strobe not active)
//   i_enable      strobe active and not acknowledged this cycle
//   o_expired     this unacknowledged cycle is the TIMEOUT_CYCLES-th one
// TIMEOUT_CYCLES = 0 disables the watchdog (o_expired stays 0).
module wb_ack_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic HAS_TIMEOUT = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Expiry is flagged in the cycle whose increment would make the count
    // reach TIMEOUT_CYCLES, so the strobe is held exactly TIMEOUT_CYCLES
    // cycles. Gating with i_enable lets a same-cycle ack win.
    assign o_expired = HAS_TIMEOUT && i_enable && (r_count == LAST);

endmodule

// File: rtl/ai_accel_wb_loader.sv
// Wishbone classic master copying len_i 32-bit words from src_addr_i to
// dst_addr_i, one read then one write per word, started by a start_i pulse.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   start_i, src_addr_i,
//   dst_addr_i, len_i           transfer request (sampled in IDLE only)
//   busy_o, done_o, err_o       status; done_o/err_o are one-cycle pulses
//   wbm_*                       Wishbone classic master port
//   dbg_state_o                 current sequencer state
// Handshake: a bus transfer completes on a clock edge where cyc, stb and
// ack_i are all 1; between every read and write (and after every write)
// the master drops cyc/stb for one cycle so registered slaves can clear ack.
module ai_accel_wb_loader
    import ai_accel_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [ADDR_W-1:0] wbm_addr_o,
    output logic [DATA_W-1:0] wbm_data_o,
    input  logic [DATA_W-1:0] wbm_data_i,
    input  logic              wbm_ack_i,
    output loader_state_t     dbg_state_o
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_rem;
    logic [DATA_W-1:0] r_buf;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;

    logic w_in_bus_state;
    logic w_count_en;
    logic w_expired;

    assign w_in_bus_state = (r_state == ST_RD) || (r_state == ST_WR);
    assign w_count_en     = w_in_bus_state && !wbm_ack_i;

    wb_ack_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_clear  (!w_in_bus_state),
        .i_enable (w_count_en),
        .o_expired(w_expired)
    );

    // Outputs are registered alongside the state: each transition loads the
    // bus/status values that belong to the state being entered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_busy <= 1'b1;
                        if (len_i != '0) begin
                            r_src   <= src_addr_i;
                            r_dst   <= dst_addr_i;
                            r_rem   <= len_i;
                            r_addr  <= src_addr_i;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_state <= ST_RD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_RD: begin
                    if (wbm_ack_i) begin
                        r_buf   <= wbm_data_i;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= ST_GAP_R;
                    end else if (w_expired) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_ABORT;
                    end
                end
                ST_GAP_R: begin
                    r_addr  <= r_dst;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= 1'b1;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    if (wbm_ack_i) begin
                        r_src   <= r_src + STRIDE;
                        r_dst   <= r_dst + STRIDE;
                        r_rem   <= r_rem - LEN_W'(1);
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_GAP_W;
                    end else if (w_expired) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_ABORT;
                    end
                end
                ST_GAP_W: begin
                    if (r_rem == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_addr  <= r_src;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= ST_RD;
                    end
                end
                ST_FIN, ST_ABORT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_we;
    assign wbm_addr_o  = r_addr;
    assign wbm_data_o  = r_buf;
    assign dbg_state_o = r_state;

endmodule
